// File: rtl/video_mode_sequencer.sv
// Resolution-switch controller: debounces the mode select, blanks video, reprograms and resets
// the PLL, waits for stable lock with timeout/retry, and reports a sticky lock failure.
`timescale 1ns/1ps
module video_mode_sequencer #(
  parameter int CFG_W           = 3,
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int BLANK_CYCLES    = 16,
  parameter int PLL_RST_CYCLES  = 8,
  parameter int LOCK_STABLE     = 256,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int MAX_RETRIES     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CFG_W-1:0]  cfg_in,
  input  logic              pll_locked,
  output logic [DATA_W-1:0] pll_data,
  output logic              pll_reset,
  output logic              video_enable,
  output logic [CFG_W-1:0]  mode,
  output logic              busy,
  output logic              error,
  output logic [2:0]        state
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > BLANK_CYCLES) ? DEBOUNCE_CYCLES : BLANK_CYCLES;
  localparam int MAX_B   = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_C > LOCK_TIMEOUT) ? MAX_C : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_T   = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] TIMEOUT_T  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_BLANK     = 3'd2,
    ST_RECONF    = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  logic [CFG_W-1:0]  cfg_meta_reg, cfg_s_reg;
  logic              lock_meta_reg, lock_s_reg;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  timer_reg, timer_next;
  logic [CNT_W-1:0]  stable_reg, stable_next;
  logic [CFG_W-1:0]  cand_reg, cand_next;
  logic [CFG_W-1:0]  mode_reg, mode_next;
  logic              mode_valid_reg, mode_valid_next;
  logic [RTY_W-1:0]  retries_reg, retries_next;
  logic [DATA_W-1:0] pll_data_reg, pll_data_next;
  logic              pll_reset_reg, pll_reset_next;
  logic              video_enable_reg, video_enable_next;
  logic              error_reg, error_next;

  logic              enter_reconf;
  logic [CNT_W-1:0]  stable_upd, timer_upd;

  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_meta_reg  <= '0;
      cfg_s_reg     <= '0;
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      cfg_meta_reg  <= cfg_in;
      cfg_s_reg     <= cfg_meta_reg;
      lock_meta_reg <= pll_locked;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  // Lock qualification counters saturate at their terminal values.
  always_comb begin
    timer_upd  = (timer_reg == TIMEOUT_T) ? timer_reg : timer_reg + CNT_W'(1);
    stable_upd = '0;
    if (lock_s_reg)
      stable_upd = (stable_reg == STABLE_T) ? stable_reg : stable_reg + CNT_W'(1);
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    timer_next        = timer_reg;
    stable_next       = stable_reg;
    cand_next         = cand_reg;
    mode_next         = mode_reg;
    mode_valid_next   = mode_valid_reg;
    retries_next      = retries_reg;
    pll_data_next     = pll_data_reg;
    pll_reset_next    = pll_reset_reg;
    video_enable_next = video_enable_reg;
    error_next        = error_reg;
    enter_reconf      = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (cfg_s_reg != mode_reg) begin
          state_next = ST_DEBOUNCE;
          cand_next  = cfg_s_reg;
          cnt_next   = '0;
        end else if (!lock_s_reg) begin
          state_next        = ST_BLANK;
          video_enable_next = 1'b0;
          cnt_next          = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (cfg_s_reg != cand_reg) begin
          cand_next = cfg_s_reg;
          cnt_next  = '0;
        end else if (cnt_reg == DEB_LAST) begin
          cnt_next = '0;
          // A glitch that settles back onto the live mode never drops video.
          if (cand_reg == mode_reg && mode_valid_reg) begin
            state_next = ST_RUN;
          end else begin
            state_next        = ST_BLANK;
            video_enable_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (cnt_reg == BLANK_LAST) enter_reconf = 1'b1;
        else cnt_next = cnt_reg + CNT_W'(1);
      end
      ST_RECONF: begin
        if (cnt_reg == RST_LAST) begin
          state_next     = ST_WAIT_LOCK;
          cnt_next       = '0;
          pll_reset_next = 1'b0;
          timer_next     = '0;
          stable_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        timer_next  = timer_upd;
        stable_next = stable_upd;
        if (stable_upd == STABLE_T) begin
          state_next        = ST_RUN;
          video_enable_next = 1'b1;
          mode_valid_next   = 1'b1;
          retries_next      = '0;
          error_next        = 1'b0;
        end else if (timer_upd == TIMEOUT_T) begin
          if (retries_reg < RTY_MAX) begin
            retries_next = retries_reg + RTY_W'(1);
            enter_reconf = 1'b1;
          end else begin
            state_next = ST_FAIL;
            error_next = 1'b1;
          end
        end
      end
      ST_FAIL: begin
        if (cfg_s_reg != mode_reg) begin
          state_next      = ST_DEBOUNCE;
          cand_next       = cfg_s_reg;
          cnt_next        = '0;
          mode_valid_next = 1'b0;
        end
      end
      default: state_next = ST_DEBOUNCE;
    endcase

    // pll_data only ever changes here, while pll_reset is being raised.
    if (enter_reconf) begin
      state_next     = ST_RECONF;
      cnt_next       = '0;
      mode_next      = cand_reg;
      pll_data_next  = DATA_W'(cand_reg);
      pll_reset_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= ST_DEBOUNCE;
      cnt_reg          <= '0;
      timer_reg        <= '0;
      stable_reg       <= '0;
      cand_reg         <= '0;
      mode_reg         <= '0;
      mode_valid_reg   <= 1'b0;
      retries_reg      <= '0;
      pll_data_reg     <= '0;
      pll_reset_reg    <= 1'b1;
      video_enable_reg <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      timer_reg        <= timer_next;
      stable_reg       <= stable_next;
      cand_reg         <= cand_next;
      mode_reg         <= mode_next;
      mode_valid_reg   <= mode_valid_next;
      retries_reg      <= retries_next;
      pll_data_reg     <= pll_data_next;
      pll_reset_reg    <= pll_reset_next;
      video_enable_reg <= video_enable_next;
      error_reg        <= error_next;
    end
  end

  assign pll_data     = pll_data_reg;
  assign pll_reset    = pll_reset_reg;
  assign video_enable = video_enable_reg;
  assign mode         = mode_reg;
  assign error        = error_reg;
  assign state        = state_reg;
  assign busy         = (state_reg != ST_RUN) && (state_reg != ST_FAIL);

endmodule
